// File: rtl/pipe3_pkg.sv
// pipe3_pkg: shared definitions for the pipelined_3_stage core.
//   - opcode values and instruction field bit positions
//   - IF/ID and ID/EX pipeline register structs
//   - instruction encoders used to build the ROM image
//   - register-file reset rule (r[i] = i)
// No ports; imported by pipelined_3_stage and pipe3_alu.
package pipe3_pkg;

   localparam int WORD_W = 32;

   // Opcodes
   localparam logic [5:0] OP_NOP  = 6'h00;
   localparam logic [5:0] OP_ADD  = 6'h01;
   localparam logic [5:0] OP_SUB  = 6'h02;
   localparam logic [5:0] OP_AND  = 6'h03;
   localparam logic [5:0] OP_OR   = 6'h04;
   localparam logic [5:0] OP_XOR  = 6'h05;
   localparam logic [5:0] OP_SLT  = 6'h06;
   localparam logic [5:0] OP_ADDI = 6'h08;

   // Instruction field bit positions
   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 26;
   localparam int RS_MSB  = 25;
   localparam int RS_LSB  = 21;
   localparam int RT_MSB  = 20;
   localparam int RT_LSB  = 16;
   localparam int RD_MSB  = 15;
   localparam int RD_LSB  = 11;
   localparam int IMM_MSB = 15;
   localparam int IMM_LSB = 0;

   // IF/ID: the fetched instruction word; all-zero is a NOP.
   typedef struct packed {
      logic [WORD_W-1:0] instr;
   } if_id_t;

   // ID/EX: decoded operation with operands already resolved
   // (register values, bypassed results or the sign-extended immediate).
   // All-zero is a NOP that writes nothing.
   typedef struct packed {
      logic [5:0]        op;
      logic [WORD_W-1:0] a;
      logic [WORD_W-1:0] b;
      logic [4:0]        dest;
      logic              we;
   } id_ex_t;

   function automatic logic [31:0] enc_r(logic [5:0] op, logic [4:0] rd,
                                         logic [4:0] rs, logic [4:0] rt);
      return {op, rs, rt, rd, 11'd0};
   endfunction

   function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rt,
                                         logic [4:0] rs, logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   // Register file contents while reset is asserted.
   function automatic logic [WORD_W-1:0] reg_init(int idx);
      return WORD_W'(idx);
   endfunction

endpackage

// File: rtl/pipe3_alu.sv
// pipe3_alu: combinational ALU for the EX stage.
// Ports:
//   op     in  6     opcode (ADDI computes the same sum as ADD)
//   a, b   in  W     operands
//   result out W     result; unrecognised opcodes give 0
module pipe3_alu
   import pipe3_pkg::*;
#(
   parameter int W = WORD_W
) (
   input  logic [5:0]   op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] result
);

   always_comb begin
      result = '0;
      case (op)
         OP_ADD, OP_ADDI: result = a + b;
         OP_SUB:          result = a - b;
         OP_AND:          result = a & b;
         OP_OR:           result = a | b;
         OP_XOR:          result = a ^ b;
         OP_SLT:          result = ($signed(a) < $signed(b)) ? W'(1) : '0;
         default:         result = '0;
      endcase
   end

endmodule

// File: rtl/pipelined_3_stage.sv
// pipelined_3_stage: self-contained 3-stage (IF, ID, EX/WB) pipeline with an
// internal instruction ROM, a 32x32 register file and a 32-bit ALU.
// Ports:
//   clk     in   1       rising-edge clock
//   rst     in   1       asynchronous active-low reset
//   aluout  out  DATA_W  registered ALU result of the instruction leaving EX
// The instruction at ROM word k (counted from reset release) appears on
// aluout after rising edge k+3. A single EX->ID bypass removes every stall.
module pipelined_3_stage
   import pipe3_pkg::*;
#(
   parameter int IMEM_DEPTH = 16,
   parameter int DATA_W     = WORD_W
) (
   input  logic              clk,
   input  logic              rst,
   output logic [DATA_W-1:0] aluout
);

   localparam int PC_W = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

   // Fixed program; every unlisted word is a NOP.
   function automatic logic [31:0] rom_word(int addr);
      case (addr)
         0:       return enc_r(OP_ADD,  5'd3, 5'd1, 5'd2);
         1:       return enc_r(OP_SUB,  5'd4, 5'd3, 5'd1);
         2:       return enc_r(OP_AND,  5'd5, 5'd4, 5'd7);
         3:       return enc_r(OP_OR,   5'd6, 5'd5, 5'd8);
         4:       return enc_r(OP_XOR,  5'd7, 5'd6, 5'd2);
         5:       return enc_r(OP_SLT,  5'd8, 5'd1, 5'd7);
         6:       return enc_i(OP_ADDI, 5'd9, 5'd0, 16'hFFFF);
         7:       return enc_r(OP_ADD,  5'd0, 5'd1, 5'd1);
         default: return 32'd0;
      endcase
   endfunction

   logic [PC_W-1:0]   pc;
   logic [31:0]       imem_word;
   if_id_t            if_id;
   id_ex_t            id_ex;
   id_ex_t            id_next;
   logic [DATA_W-1:0] rf [32];
   logic [DATA_W-1:0] alu_result;

   // ---------------- IF ----------------
   always_comb imem_word = rom_word(int'(pc));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc    <= '0;
         if_id <= '0;
      end else begin
         if_id.instr <= imem_word;
         pc          <= (pc == PC_W'(IMEM_DEPTH - 1)) ? '0 : pc + PC_W'(1);
      end
   end

   // ---------------- ID ----------------
   logic [5:0]        id_op;
   logic [4:0]        id_rs;
   logic [4:0]        id_rt;
   logic [4:0]        id_rd;
   logic [15:0]       id_imm;
   logic [DATA_W-1:0] rs_val;
   logic [DATA_W-1:0] rt_val;

   always_comb begin
      id_op  = if_id.instr[OPC_MSB:OPC_LSB];
      id_rs  = if_id.instr[RS_MSB:RS_LSB];
      id_rt  = if_id.instr[RT_MSB:RT_LSB];
      id_rd  = if_id.instr[RD_MSB:RD_LSB];
      id_imm = if_id.instr[IMM_MSB:IMM_LSB];
   end

   // id_ex.we is only ever set for a non-zero destination, so a match here
   // already implies the bypass is meaningful. Results written two cycles
   // earlier are already in rf, so no second bypass level is needed.
   always_comb begin
      rs_val = (id_rs == 5'd0) ? '0 : rf[id_rs];
      rt_val = (id_rt == 5'd0) ? '0 : rf[id_rt];
      if (id_ex.we && (id_ex.dest == id_rs)) rs_val = alu_result;
      if (id_ex.we && (id_ex.dest == id_rt)) rt_val = alu_result;
   end

   always_comb begin
      id_next = '0;
      case (id_op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT: begin
            id_next.op   = id_op;
            id_next.a    = rs_val;
            id_next.b    = rt_val;
            id_next.dest = id_rd;
            id_next.we   = (id_rd != 5'd0);
         end
         OP_ADDI: begin
            id_next.op   = id_op;
            id_next.a    = rs_val;
            id_next.b    = {{(DATA_W-16){id_imm[15]}}, id_imm};
            id_next.dest = id_rt;
            id_next.we   = (id_rt != 5'd0);
         end
         default: id_next = '0;  // NOP and unknown opcodes
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) id_ex <= '0;
      else      id_ex <= id_next;
   end

   // ---------------- EX / WB ----------------
   pipe3_alu #(.W(DATA_W)) u_alu (
      .op     (id_ex.op),
      .a      (id_ex.a),
      .b      (id_ex.b),
      .result (alu_result)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         aluout <= '0;
         for (int i = 0; i < 32; i++) rf[i] <= reg_init(i);
      end else begin
         aluout <= alu_result;
         if (id_ex.we) rf[id_ex.dest] <= alu_result;
      end
   end

endmodule

// File: tb/tb_pipelined_3_stage.sv
// tb_pipelined_3_stage: self-checking bench for pipelined_3_stage.
// Expected aluout values come from an instruction-level model that executes
// the program one instruction at a time on an architectural register array.
module tb_pipelined_3_stage;

   logic        clk;
   logic        rst;
   logic [31:0] aluout;

   int checks = 0;
   int errors = 0;

   pipelined_3_stage dut (
      .clk    (clk),
      .rst    (rst),
      .aluout (aluout)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct {
      int          op;
      int          rd;
      int          rs;
      int          rt;
      logic [15:0] imm;
   } instr_t;

   instr_t      prog [16];
   logic [31:0] mregs [32];
   int          mk;

   function automatic void model_reset();
      for (int i = 0; i < 32; i++) mregs[i] = 32'(i);
      mk = 0;
   endfunction

   // Execute the next program instruction; return the value aluout shows.
   function automatic logic [31:0] model_exec();
      instr_t      in;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      int          dest;
      in   = prog[mk % 16];
      mk   = mk + 1;
      a    = (in.rs == 0) ? 32'd0 : mregs[in.rs];
      b    = (in.rt == 0) ? 32'd0 : mregs[in.rt];
      r    = 32'd0;
      dest = 0;
      case (in.op)
         1: begin r = a + b; dest = in.rd; end
         2: begin r = a - b; dest = in.rd; end
         3: begin r = a & b; dest = in.rd; end
         4: begin r = a | b; dest = in.rd; end
         5: begin r = a ^ b; dest = in.rd; end
         6: begin r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; dest = in.rd; end
         8: begin r = a + {{16{in.imm[15]}}, in.imm}; dest = in.rt; end
         default: begin r = 32'd0; dest = 0; end
      endcase
      if (dest != 0) mregs[dest] = r;
      return r;
   endfunction

   // ---------------- directed vectors ----------------
   typedef struct {
      int          edge_n;
      logic [31:0] exp;
   } vec_t;

   localparam int NV = 15;
   vec_t vec [NV];

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Run n edges after reset release, comparing every edge against the model
   // and, optionally, against the directed table.
   task automatic run_edges(input int n, input bit use_table);
      logic [31:0] exp;
      for (int e = 1; e <= n; e++) begin
         @(posedge clk);
         #1;
         exp = (e < 3) ? 32'd0 : model_exec();
         check($sformatf("model_edge%0d", e), aluout, exp);
         if (use_table)
            for (int t = 0; t < NV; t++)
               if (vec[t].edge_n == e)
                  check($sformatf("table_edge%0d", e), aluout, vec[t].exp);
      end
   endtask

   // Assert reset between edges, check it takes effect at once, hold, release.
   task automatic async_reset(input int hold);
      #2;
      rst = 1'b0;
      #1;
      check("async_reset", aluout, 32'd0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("reset_hold", aluout, 32'd0);
      end
      model_reset();
      @(negedge clk);
      rst = 1'b1;
   endtask

   // ---------------- test ----------------
   initial begin
      for (int i = 0; i < 16; i++) prog[i] = '{0, 0, 0, 0, 16'h0};
      prog[0] = '{1, 3, 1, 2, 16'h0};
      prog[1] = '{2, 4, 3, 1, 16'h0};
      prog[2] = '{3, 5, 4, 7, 16'h0};
      prog[3] = '{4, 6, 5, 8, 16'h0};
      prog[4] = '{5, 7, 6, 2, 16'h0};
      prog[5] = '{6, 8, 1, 7, 16'h0};
      prog[6] = '{8, 0, 0, 9, 16'hFFFF};
      prog[7] = '{1, 0, 1, 1, 16'h0};

      vec[0]  = '{1,  32'd0};
      vec[1]  = '{2,  32'd0};
      vec[2]  = '{3,  32'd3};
      vec[3]  = '{4,  32'd2};
      vec[4]  = '{5,  32'd2};
      vec[5]  = '{6,  32'd10};
      vec[6]  = '{7,  32'd8};
      vec[7]  = '{8,  32'd1};
      vec[8]  = '{9,  32'hFFFF_FFFF};
      vec[9]  = '{10, 32'd2};
      vec[10] = '{11, 32'd0};
      vec[11] = '{19, 32'd3};
      vec[12] = '{20, 32'd2};
      vec[13] = '{21, 32'd0};   // AND r5 = r4 & r7 = 2 & 8 on the second pass
      vec[14] = '{22, 32'd1};   // OR r6 = r5 | r8 = 0 | 1

      // Reset hold for 5 cycles.
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("reset_hold", aluout, 32'd0);
      end
      rst = 1'b1;

      // First run including wrap-around, then an async reset mid-cycle.
      run_edges(24, 1'b1);
      async_reset(2);

      // Reset at edge 6, then the full sequence again from edge 3.
      run_edges(6, 1'b1);
      async_reset(1);
      run_edges(12, 1'b1);

      // Random run lengths with random reset hold times.
      for (int r = 0; r < 6; r++) begin
         async_reset($urandom_range(0, 3));
         run_edges($urandom_range(1, 40), 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
